// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmit FIFO write port.
// A granted source keeps the port until its packet ends, MAX_LEN bytes pass, or it drops req.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int DBIT    = 8,
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      req,
  input  logic [N*DBIT-1:0] src_data,
  input  logic [N-1:0]      src_last,
  output logic [N-1:0]      ack,
  output logic [DBIT-1:0]   w_data,
  output logic              wr_uart,
  input  logic              tx_full,
  output logic              busy,
  output logic [2:0]        owner
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [2:0]      rr_ptr;
  logic [7:0]      byte_cnt;
  logic [2:0]      grant_idx;
  logic            grant_vld;
  logic [3:0]      best_d;
  logic            own_req, own_last;
  logic [DBIT-1:0] own_data;
  logic            accept, release_pkt;

  // Cyclic distance from rr_ptr+1; the requester closest to it wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    best_d    = '0;
    for (int j = 0; j < N; j++) begin
      logic [3:0] d;
      d = 4'(j) + 4'(N) - 4'(rr_ptr) - 4'd1;
      if (d >= 4'(N)) d = d - 4'(N);
      if (req[j] && (!grant_vld || d < best_d)) begin
        grant_vld = 1'b1;
        grant_idx = 3'(j);
        best_d    = d;
      end
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int j = 0; j < N; j++) begin
      if (owner == 3'(j)) begin
        own_req  = req[j];
        own_last = src_last[j];
        own_data = src_data[j*DBIT +: DBIT];
      end
    end
  end

  assign accept      = (state == SEND) && own_req && !tx_full;
  assign release_pkt = (state == SEND) &&
                       ((accept && (own_last || byte_cnt == 8'(MAX_LEN - 1))) || !own_req);
  assign wr_uart     = accept;
  assign w_data      = accept ? own_data : '0;
  assign busy        = (state == SEND);

  always_comb begin
    for (int j = 0; j < N; j++) ack[j] = accept && (owner == 3'(j));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = SEND;
      SEND:    if (release_pkt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= 3'(N - 1);
      owner    <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_vld) begin
        owner    <= grant_idx;
        byte_cnt <= '0;
      end
      if (accept) byte_cnt <= byte_cnt + 8'd1;
      if (release_pkt) rr_ptr <= owner;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-vector bench for uart_tx_arbiter: each cycle drives inputs on the
// falling edge and checks the combinational outputs shortly after.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] src_data;
  logic [3:0]  src_last;
  logic [3:0]  ack;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        tx_full;
  logic        busy;
  logic [2:0]  owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(4), .DBIT(8), .MAX_LEN(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .src_data(src_data),
    .src_last(src_last), .ack(ack), .w_data(w_data), .wr_uart(wr_uart),
    .tx_full(tx_full), .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv_chk(input string tag, input logic [3:0] r, input logic [31:0] sd,
                         input logic [3:0] sl, input logic tf,
                         input logic e_wr, input logic [7:0] e_wd, input logic [3:0] e_ack,
                         input logic e_busy, input logic [2:0] e_own);
    req = r; src_data = sd; src_last = sl; tx_full = tf;
    #1;
    chk($sformatf("%s.wr", tag),    32'(wr_uart), 32'(e_wr));
    chk($sformatf("%s.wdata", tag), 32'(w_data),  32'(e_wd));
    chk($sformatf("%s.ack", tag),   32'(ack),     32'(e_ack));
    chk($sformatf("%s.busy", tag),  32'(busy),    32'(e_busy));
    chk($sformatf("%s.owner", tag), 32'(owner),   32'(e_own));
  endtask

  task automatic cyc(input string tag, input logic [3:0] r, input logic [31:0] sd,
                     input logic [3:0] sl, input logic tf,
                     input logic e_wr, input logic [7:0] e_wd, input logic [3:0] e_ack,
                     input logic e_busy, input logic [2:0] e_own);
    @(negedge clk);
    drv_chk(tag, r, sd, sl, tf, e_wr, e_wd, e_ack, e_busy, e_own);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req = '0; src_data = '0; src_last = '0; tx_full = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; req = '0; src_data = '0; src_last = '0; tx_full = 1'b0;
    // reset state
    #12;
    chk("rst.wr", 32'(wr_uart), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.wdata", 32'(w_data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.owner", 32'(owner), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // source 0: 3-byte packet 41 42 43
    cyc("t1.idle", 4'b0001, 32'h0000_0041, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0);
    cyc("t1.b0",   4'b0001, 32'h0000_0041, 4'b0000, 0, 1, 8'h41, 4'b0001, 1, 0);
    cyc("t1.b1",   4'b0001, 32'h0000_0042, 4'b0000, 0, 1, 8'h42, 4'b0001, 1, 0);
    cyc("t1.b2",   4'b0001, 32'h0000_0043, 4'b0001, 0, 1, 8'h43, 4'b0001, 1, 0);
    cyc("t1.done", 4'b0000, 32'h0,         4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0);

    // all four request 1-byte packets: 0,1,2,3,0 with IDLE between
    do_reset();
    cyc("t2.i0", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 0, 8'h00, 4'b0000, 0, 0);
    cyc("t2.g0", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 1, 8'hA0, 4'b0001, 1, 0);
    cyc("t2.i1", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 0, 8'h00, 4'b0000, 0, 0);
    cyc("t2.g1", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 1, 8'hA1, 4'b0010, 1, 1);
    cyc("t2.i2", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 0, 8'h00, 4'b0000, 0, 1);
    cyc("t2.g2", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 1, 8'hA2, 4'b0100, 1, 2);
    cyc("t2.i3", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 0, 8'h00, 4'b0000, 0, 2);
    cyc("t2.g3", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 1, 8'hA3, 4'b1000, 1, 3);
    cyc("t2.i4", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 0, 8'h00, 4'b0000, 0, 3);
    cyc("t2.g4", 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 1, 8'hA0, 4'b0001, 1, 0);

    // source 2: 20 bytes without last, capped at 16; source 1 slips in between
    do_reset();
    cyc("t3.idle", 4'b0100, 32'h0001_0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0);
    for (int k = 1; k <= 16; k++)
      cyc($sformatf("t3.b%0d", k), 4'b0110, {8'h00, 8'(k), 8'h51, 8'h00}, 4'b0010, 0,
          1, 8'(k), 4'b0100, 1, 2);
    cyc("t3.cap",  4'b0110, 32'h0011_5100, 4'b0010, 0, 0, 8'h00, 4'b0000, 0, 2);
    cyc("t3.s1",   4'b0110, 32'h0011_5100, 4'b0010, 0, 1, 8'h51, 4'b0010, 1, 1);
    cyc("t3.idl2", 4'b0100, 32'h0011_0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 1);
    for (int k = 17; k <= 20; k++)
      cyc($sformatf("t3.b%0d", k), 4'b0100, {8'h00, 8'(k), 8'h00, 8'h00},
          (k == 20) ? 4'b0100 : 4'b0000, 0, 1, 8'(k), 4'b0100, 1, 2);
    cyc("t3.done", 4'b0000, 32'h0, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 2);

    // source 1 stalled by tx_full for 10 cycles mid-packet
    do_reset();
    cyc("t4.idle", 4'b0010, 32'h0000_6100, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0);
    cyc("t4.b0",   4'b0010, 32'h0000_6100, 4'b0000, 0, 1, 8'h61, 4'b0010, 1, 1);
    cyc("t4.b1",   4'b0010, 32'h0000_6200, 4'b0000, 0, 1, 8'h62, 4'b0010, 1, 1);
    for (int k = 0; k < 10; k++)
      cyc($sformatf("t4.full%0d", k), 4'b0010, 32'h0000_6300, 4'b0000, 1,
          0, 8'h00, 4'b0000, 1, 1);
    cyc("t4.b2",   4'b0010, 32'h0000_6300, 4'b0000, 0, 1, 8'h63, 4'b0010, 1, 1);
    cyc("t4.b3",   4'b0010, 32'h0000_6400, 4'b0010, 0, 1, 8'h64, 4'b0010, 1, 1);
    cyc("t4.done", 4'b0000, 32'h0,         4'b0000, 0, 0, 8'h00, 4'b0000, 0, 1);

    // source 3 abandons after 2 bytes; pending source 0 is next
    cyc("t5.idle", 4'b1000, 32'h7100_0000, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 1);
    cyc("t5.b0",   4'b1001, 32'h7100_0001, 4'b0001, 0, 1, 8'h71, 4'b1000, 1, 3);
    cyc("t5.b1",   4'b1001, 32'h7200_0001, 4'b0001, 0, 1, 8'h72, 4'b1000, 1, 3);
    cyc("t5.drop", 4'b0001, 32'h0000_0001, 4'b0001, 0, 0, 8'h00, 4'b0000, 1, 3);
    cyc("t5.idl2", 4'b0001, 32'h0000_0001, 4'b0001, 0, 0, 8'h00, 4'b0000, 0, 3);
    cyc("t5.s0",   4'b0001, 32'h0000_0001, 4'b0001, 0, 1, 8'h01, 4'b0001, 1, 0);
    cyc("t5.done", 4'b0000, 32'h0,         4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0);

    // reset mid-SEND of source 1, then both 0 and 1 request: 0 first
    cyc("t6.i",    4'b0010, 32'h0000_8100, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0);
    cyc("t6.b0",   4'b0010, 32'h0000_8100, 4'b0000, 0, 1, 8'h81, 4'b0010, 1, 1);
    @(negedge clk);
    reset_n = 1'b0;
    drv_chk("t6.rst", 4'b0010, 32'h0000_8200, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drv_chk("t6.idle", 4'b0011, 32'h0000_8291, 4'b0011, 0, 0, 8'h00, 4'b0000, 0, 0);
    cyc("t6.s0",   4'b0011, 32'h0000_8291, 4'b0011, 0, 1, 8'h91, 4'b0001, 1, 0);
    cyc("t6.idl2", 4'b0010, 32'h0000_8200, 4'b0010, 0, 0, 8'h00, 4'b0000, 0, 0);
    cyc("t6.s1",   4'b0010, 32'h0000_8200, 4'b0010, 0, 1, 8'h82, 4'b0010, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
